// File: rtl/weakbus_arbiter.sv
// Round-robin arbiter sharing one weakcore slave bus between two masters.
// Optional busy timeout with sticky bus_err is enabled by defining WEAKBUS_TIMEOUT_EN.
module weakbus_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic                m0_wr,
    input  logic [DATA_W/8-1:0] m0_wr_mask,
    input  logic [DATA_W-1:0]   m0_out,
    output logic [DATA_W-1:0]   m0_in,
    output logic                m0_ack,
    input  logic                m1_req,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic                m1_wr,
    input  logic [DATA_W/8-1:0] m1_wr_mask,
    input  logic [DATA_W-1:0]   m1_out,
    output logic [DATA_W-1:0]   m1_in,
    output logic                m1_ack,
    output logic                s_req,
    output logic [ADDR_W-1:0]   s_addr,
    output logic                s_wr,
    output logic [DATA_W/8-1:0] s_wr_mask,
    output logic [DATA_W-1:0]   s_out,
    input  logic [DATA_W-1:0]   s_in,
    input  logic                s_ack,
    output logic                grant,
    output logic                bus_err
);

    localparam int unsigned MaskW = DATA_W / 8;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e              state_q, state_d;
    logic                last_q;
    logic                grant_q;
    logic [ADDR_W-1:0]   s_addr_q;
    logic                s_wr_q;
    logic [MaskW-1:0]    s_wr_mask_q;
    logic [DATA_W-1:0]   s_out_q;

    logic winner;
    logic start;
    logic done_ok;
    logic expire;
    logic finish;

    // On a tie the master that did not win last time takes the bus.
    assign winner  = (m0_req && m1_req) ? ~last_q : m1_req;
    assign start   = (state_q == StIdle) && (m0_req || m1_req);
    assign done_ok = (state_q == StBusy) && s_ack;
    assign finish  = done_ok || expire;

`ifdef WEAKBUS_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;
    logic            bus_err_q;

    assign expire = (state_q == StBusy) && !s_ack && (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (start) begin
                cnt_q <= '0;
            end else if (state_q == StBusy && !finish) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (expire) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign expire         = 1'b0;
    assign bus_err        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start)  state_d = StBusy;
            StBusy:  if (finish) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Latched transaction and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= 1'b1;
            grant_q     <= 1'b0;
            s_addr_q    <= '0;
            s_wr_q      <= 1'b0;
            s_wr_mask_q <= '0;
            s_out_q     <= '0;
        end else if (start) begin
            grant_q     <= winner;
            s_addr_q    <= winner ? m1_addr    : m0_addr;
            s_wr_q      <= winner ? m1_wr      : m0_wr;
            s_wr_mask_q <= winner ? m1_wr_mask : m0_wr_mask;
            s_out_q     <= winner ? m1_out     : m0_out;
        end else if (finish) begin
            last_q <= grant_q;
        end
    end

    // Outputs; a completion is never forwarded during a reset cycle.
    always_comb begin
        logic [DATA_W-1:0] rdata;
        logic              fire;

        fire  = finish && !rst;
        rdata = done_ok ? s_in : {DATA_W{1'b1}};

        s_req     = (state_q == StBusy);
        s_addr    = s_addr_q;
        s_wr      = s_wr_q;
        s_wr_mask = s_wr_mask_q;
        s_out     = s_out_q;
        grant     = grant_q;

        m0_ack = fire && !grant_q;
        m1_ack = fire && grant_q;
        m0_in  = m0_ack ? rdata : '0;
        m1_in  = m1_ack ? rdata : '0;
    end

endmodule

// File: tb/tb_weakbus_arbiter.sv
// Bench for weakbus_arbiter: directed scenarios plus random traffic checked against
// a transaction-level reference model; the timeout scenario runs when WEAKBUS_TIMEOUT_EN is set.
module tb_weakbus_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m1_req, m0_wr, m1_wr, m0_ack, m1_ack;
    logic [ADDR_W-1:0] m0_addr, m1_addr, s_addr;
    logic [3:0]        m0_wr_mask, m1_wr_mask, s_wr_mask;
    logic [DATA_W-1:0] m0_out, m1_out, m0_in, m1_in, s_out, s_in;
    logic              s_req, s_wr, s_ack, grant, bus_err;

    always #5 clk = ~clk;

    weakbus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr(m0_wr), .m0_wr_mask(m0_wr_mask),
        .m0_out(m0_out), .m0_in(m0_in), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr(m1_wr), .m1_wr_mask(m1_wr_mask),
        .m1_out(m1_out), .m1_in(m1_in), .m1_ack(m1_ack),
        .s_req(s_req), .s_addr(s_addr), .s_wr(s_wr), .s_wr_mask(s_wr_mask),
        .s_out(s_out), .s_in(s_in), .s_ack(s_ack), .grant(grant), .bus_err(bus_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    endtask

    // Reference model: one outstanding transaction with its owner and contents.
    bit              mdl_busy, mdl_owner, mdl_last, mdl_err;
    bit [ADDR_W-1:0] mdl_addr;
    bit              mdl_wr;
    bit [3:0]        mdl_mask;
    bit [DATA_W-1:0] mdl_data;
    int unsigned     mdl_age;

    bit              obs_ack0, obs_ack1;
    bit [DATA_W-1:0] obs_in0;
    int              ack_seq[$];
    int unsigned     sl_wait;

    task automatic mdl_reset();
        mdl_busy = 0; mdl_last = 1; mdl_err = 0; mdl_age = 0; mdl_owner = 0;
    endtask

    // Inputs are already set at a falling edge; check, advance the model, move to next falling edge.
    task automatic step();
        bit              fire, timed_out;
        bit [DATA_W-1:0] rdata;
        #1;
        obs_ack0 = m0_ack; obs_ack1 = m1_ack; obs_in0 = m0_in;
        if (m0_ack) ack_seq.push_back(0);
        if (m1_ack) ack_seq.push_back(1);
        if (rst) begin
            check_eq("rst_ack0", {63'd0, m0_ack}, 64'd0);
            check_eq("rst_ack1", {63'd0, m1_ack}, 64'd0);
            mdl_reset();
        end else begin
            fire = 0; timed_out = 0; rdata = '0;
            check_eq("s_req", {63'd0, s_req}, {63'd0, mdl_busy});
            check_eq("bus_err", {63'd0, bus_err}, {63'd0, mdl_err});
            if (mdl_busy) begin
                check_eq("grant", {63'd0, grant}, {63'd0, mdl_owner});
                check_eq("s_addr", 64'(s_addr), 64'(mdl_addr));
                check_eq("s_wr", {63'd0, s_wr}, {63'd0, mdl_wr});
                check_eq("s_wr_mask", 64'(s_wr_mask), 64'(mdl_mask));
                check_eq("s_out", 64'(s_out), 64'(mdl_data));
                if (s_ack) begin
                    fire = 1; rdata = s_in;
                end
`ifdef WEAKBUS_TIMEOUT_EN
                else if (mdl_age + 1 == TIMEOUT) begin
                    fire = 1; timed_out = 1; rdata = '1;
                end
`endif
            end
            check_eq("m0_ack", {63'd0, m0_ack}, {63'd0, fire && !mdl_owner});
            check_eq("m1_ack", {63'd0, m1_ack}, {63'd0, fire && mdl_owner});
            check_eq("m0_in", 64'(m0_in), (fire && !mdl_owner) ? 64'(rdata) : 64'd0);
            check_eq("m1_in", 64'(m1_in), (fire && mdl_owner) ? 64'(rdata) : 64'd0);
            if (mdl_busy) begin
                if (fire) begin
                    mdl_busy = 0; mdl_last = mdl_owner;
                    if (timed_out) mdl_err = 1;
                end else begin
                    mdl_age++;
                end
            end else if (m0_req || m1_req) begin
                mdl_owner = (m0_req && m1_req) ? !mdl_last : m1_req;
                mdl_addr  = mdl_owner ? m1_addr : m0_addr;
                mdl_wr    = mdl_owner ? m1_wr : m0_wr;
                mdl_mask  = mdl_owner ? m1_wr_mask : m0_wr_mask;
                mdl_data  = mdl_owner ? m1_out : m0_out;
                mdl_busy  = 1; mdl_age = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; m0_req = 0; m1_req = 0; s_ack = 0; s_in = '0;
        step(); step();
        rst = 0;
        check_eq("rst_s_req", {63'd0, s_req}, 64'd0);
        check_eq("rst_grant", {63'd0, grant}, 64'd0);
        check_eq("rst_s_addr", 64'(s_addr), 64'd0);
        check_eq("rst_s_out", 64'(s_out), 64'd0);
        check_eq("rst_s_mask", {60'd0, s_wr_mask}, 64'd0);
        check_eq("rst_s_wr", {63'd0, s_wr}, 64'd0);
        check_eq("rst_bus_err", {63'd0, bus_err}, 64'd0);
        ack_seq.delete(); sl_wait = 0; obs_ack0 = 0; obs_ack1 = 0;
    endtask

    // Slave acks lat cycles after s_req rises; masters drop after ack unless kept requesting.
    task automatic run(input int cycles, input bit keep0, input bit keep1, input int unsigned lat);
        for (int i = 0; i < cycles; i++) begin
            if (obs_ack0 && !keep0) m0_req = 0;
            if (obs_ack1 && !keep1) m1_req = 0;
            if (s_req) begin
                s_ack   = (sl_wait == lat);
                s_in    = $urandom;
                sl_wait = s_ack ? 0 : sl_wait + 1;
            end else begin
                s_ack = 0; sl_wait = 0;
            end
            step();
        end
    endtask

    initial begin
        int n;
        rst = 1;
        m0_req = 0; m0_addr = '0; m0_wr = 0; m0_wr_mask = '0; m0_out = '0;
        m1_req = 0; m1_addr = '0; m1_wr = 0; m1_wr_mask = '0; m1_out = '0;
        s_ack = 0; s_in = '0;
        mdl_reset();
        @(negedge clk);
        do_reset();

        // m0 read, slave acks two cycles after s_req with fixed data
        m0_req = 1; m0_addr = 32'h100; m0_wr = 0; m0_wr_mask = 4'hf;
        step();
        check_eq("t1_s_req", {63'd0, s_req}, 64'd1);
        step(); step();
        s_ack = 1; s_in = 32'hDEADBEEF;
        step();
        check_eq("t1_ack0", {63'd0, obs_ack0}, 64'd1);
        check_eq("t1_in0", 64'(obs_in0), 64'hDEADBEEF);
        m0_req = 0; s_ack = 0;
        step();
        check_eq("t1_count", 64'(ack_seq.size()), 64'd1);

        // Simultaneous requests after reset: m0 then m1
        do_reset();
        m0_req = 1; m1_req = 1; m1_addr = 32'h44;
        run(8, 0, 0, 1);
        check_eq("t2_count", 64'(ack_seq.size()), 64'd2);
        n = ack_seq.size();
        for (int i = 0; i < n; i++) check_eq("t2_seq", 64'(ack_seq[i]), 64'(i % 2));

        // m1 unaligned byte write held stable until ack
        do_reset();
        m1_req = 1; m1_addr = 32'h203; m1_wr = 1; m1_wr_mask = 4'b1000; m1_out = 32'hAA000000;
        step();
        check_eq("t3_addr", 64'(s_addr), 64'h203);
        check_eq("t3_mask", {60'd0, s_wr_mask}, 64'h8);
        run(6, 0, 0, 2);
        check_eq("t3_owner", (ack_seq.size() == 1) ? 64'(ack_seq[0]) : 64'hbad, 64'd1);

        // Continuous requests from both: strict alternation
        do_reset();
        m0_req = 1; m1_req = 1;
        run(12, 1, 1, 0);
        m0_req = 0; m1_req = 0; s_ack = 0;
        step();
        check_eq("t4_count", 64'(ack_seq.size()), 64'd6);
        n = ack_seq.size();
        for (int i = 0; i < n; i++) check_eq("t4_seq", 64'(ack_seq[i]), 64'(i % 2));

        // Reset while busy, late ack ignored
        do_reset();
        m1_req = 1;
        step(); step();
        rst = 1; m1_req = 0;
        step();
        rst = 0; s_ack = 1; s_in = 32'h12345678;
        step();
        check_eq("t5_s_req", {63'd0, s_req}, 64'd0);
        check_eq("t5_grant", {63'd0, grant}, 64'd0);
        check_eq("t5_no_ack", 64'(ack_seq.size()), 64'd0);
        s_ack = 0;
        step();

        // Random traffic, with occasional stray s_ack while idle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m0_req && obs_ack0) m0_req = $urandom_range(0, 1);
            else if (!m0_req) m0_req = ($urandom_range(0, 2) == 0);
            if (m0_req && (obs_ack0 || !mdl_busy || mdl_owner)) begin
                if (obs_ack0 || !s_req) begin
                    m0_addr = $urandom; m0_wr = $urandom; m0_wr_mask = $urandom; m0_out = $urandom;
                end
            end
            if (m1_req && obs_ack1) m1_req = $urandom_range(0, 1);
            else if (!m1_req) m1_req = ($urandom_range(0, 2) == 0);
            if (m1_req && (obs_ack1 || !s_req)) begin
                m1_addr = $urandom; m1_wr = $urandom; m1_wr_mask = $urandom; m1_out = $urandom;
            end
            s_in = $urandom;
            if (s_req) begin
                s_ack   = (sl_wait == 0);
                sl_wait = s_ack ? $urandom_range(0, 3) : sl_wait - 1;
            end else begin
                s_ack = ($urandom_range(0, 7) == 0);
            end
            step();
        end
        m0_req = 0; m1_req = 0; s_ack = 0;
        step(); step();

`ifdef WEAKBUS_TIMEOUT_EN
        // Slave never acks: forced completion in the TIMEOUT-th busy cycle
        do_reset();
        m0_req = 1; m0_wr = 0; m0_addr = 32'h80;
        step();
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            step();
            if (obs_ack0) n = i;
        end
        check_eq("to_cycle", 64'(n), 64'(TIMEOUT));
        check_eq("to_in", 64'(obs_in0), 64'hFFFFFFFF);
        m0_req = 0;
        step(); step(); step();
        check_eq("to_err_sticky", {63'd0, bus_err}, 64'd1);
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
